sr_bank_ctrl: RTL and testbench

SR_BANK_CTRL -- requirements
Module: sr_bank_ctrl

---
 rtl/sr_bank_ctrl.sv | 102 ++++++++++
 tb/tb_sr_bank_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/sr_bank_ctrl.sv
// sr_bank_ctrl: round-robin arbitrated set/clear/toggle/read controller for a 4-flag SR flop bank.
module sr_bank_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  input  logic [1:0] op0,
  input  logic [1:0] op1,
  input  logic [1:0] idx0,
  input  logic [1:0] idx1,
  input  logic [3:0] q,
  output logic [3:0] s,
  output logic [3:0] r,
  output logic       ack0,
  output logic       ack1,
  output logic       rdata,
  output logic       err,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;
  state_t     state_q, state_d;
  logic       gnt_q, gnt_d, exp_q, exp_d;
  logic [1:0] idx_q, idx_d, op_sel;
  logic [3:0] s_q, s_d, r_q, r_d;
  logic       ack0_q, ack0_d, ack1_q, ack1_d, rdata_q, rdata_d, err_q, err_d, busy_q, busy_d;
  logic       cur, set_op, clr_op;
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    exp_d   = exp_q;
    s_d     = '0;
    r_d     = '0;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    rdata_d = 1'b0;
    err_d   = 1'b0;
    op_sel  = '0;
    cur     = 1'b0;
    set_op  = 1'b0;
    clr_op  = 1'b0;
    unique case (state_q)
      IDLE: if (req0 || req1) begin
        gnt_d   = (req0 && req1) ? ~gnt_q : req1;
        op_sel  = gnt_d ? op1 : op0;
        idx_d   = gnt_d ? idx1 : idx0;
        cur     = q[idx_d];
        set_op  = (op_sel == 2'b01) || (op_sel == 2'b11 && !cur);
        clr_op  = (op_sel == 2'b10) || (op_sel == 2'b11 && cur);
        exp_d   = set_op || (!clr_op && cur);
        s_d     = set_op ? 4'b0001 << idx_d : 4'b0000;
        r_d     = clr_op ? 4'b0001 << idx_d : 4'b0000;
        state_d = DRIVE;
      end
      DRIVE: state_d = CHECK;
      CHECK: begin
        ack0_d  = !gnt_q;
        ack1_d  = gnt_q;
        rdata_d = q[idx_q];
        err_d   = q[idx_q] != exp_q;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  // gnt_q holds the last granted requester; resetting it to 1 lets req0 win the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= 1'b1;
      idx_q   <= '0;
      exp_q   <= 1'b0;
      s_q     <= '0;
      r_q     <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      rdata_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      exp_q   <= exp_d;
      s_q     <= s_d;
      r_q     <= r_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end
  assign s     = s_q;
  assign r     = r_q;
  assign ack0  = ack0_q;
  assign ack1  = ack1_q;
  assign rdata = rdata_q;
  assign err   = err_q;
  assign busy  = busy_q;
endmodule

// File: tb/tb_sr_bank_ctrl.sv
// tb_sr_bank_ctrl: directed and random checks of sr_bank_ctrl against a transaction-timeline model.
module tb_sr_bank_ctrl;
  logic       clk = 1'b0, rst_n = 1'b0, load_en = 1'b1;
  logic       rq[2];
  logic [1:0] opv[2], ixv[2];
  logic [3:0] q, s, r, tb_bank = '0, stuck = '0, load_val = '0, mb = '0;
  logic       ack0, ack1, rdata, err, busy;
  int n_pass = 0, n_total = 0, cyc = 0, mode = 0;
  int g_cyc = -100, m_free = 0, m_last = 1, e_g = 0, c = 0;
  logic [3:0] e_s = '0, e_r = '0;
  logic       e_rd = 1'b0, e_err = 1'b0, last_rd = 1'b0, last_err = 1'b0;
  int last_ack_cyc = 0;
  int acks[$], ack_cycs[$];

  sr_bank_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req0(rq[0]), .req1(rq[1]), .op0(opv[0]), .op1(opv[1]), .idx0(ixv[0]), .idx1(ixv[1]),
    .q(q), .s(s), .r(r), .ack0(ack0), .ack1(ack1), .rdata(rdata), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;
  assign q = tb_bank & ~stuck;
  always @(posedge clk) tb_bank <= load_en ? load_val : (tb_bank & ~r) | s;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // One request is in flight at a time: grant at cycle g, drive at g+1, ack at g+3, next sample at g+4
  task automatic model_step();
    int g;
    logic cur, want, drv;
    logic [3:0] seen;
    if (!rst_n) begin
      g_cyc = -100; m_last = 1; m_free = cyc + 1;
    end else if (cyc >= m_free && (rq[0] || rq[1])) begin
      g = (rq[0] && rq[1]) ? (m_last == 1 ? 0 : 1) : (rq[1] ? 1 : 0);
      m_last = g;
      seen = mb & ~stuck;
      cur = seen[ixv[g]];
      drv = opv[g] != 2'd0;
      want = (opv[g] == 2'd1) ? 1'b1 : (opv[g] == 2'd2) ? 1'b0 : (opv[g] == 2'd3) ? !cur : cur;
      e_s = (drv && want) ? 4'(1 << ixv[g]) : 4'd0;
      e_r = (drv && !want) ? 4'(1 << ixv[g]) : 4'd0;
      if (drv) mb[ixv[g]] = want;
      seen = mb & ~stuck;
      e_rd = seen[ixv[g]];
      e_err = e_rd != want;
      e_g = g; g_cyc = cyc; m_free = cyc + 4;
    end
  endtask

  task automatic check_outputs();
    int d;
    d = cyc - g_cyc;
    chk("s", 8'(s), 8'(d == 1 ? e_s : 4'd0));
    chk("r", 8'(r), 8'(d == 1 ? e_r : 4'd0));
    chk("ack", 8'({ack1, ack0}), 8'(d == 3 ? (e_g == 1 ? 2'b10 : 2'b01) : 2'b00));
    chk("rdata", 8'(rdata), 8'(d == 3 && e_rd));
    chk("err", 8'(err), 8'(d == 3 && e_err));
    chk("busy", 8'(busy), 8'(d >= 1 && d <= 3));
    chk("s_and_r", 8'(s & r), 8'd0);
  endtask

  task automatic tick();
    logic a[2];
    model_step();
    @(negedge clk);
    cyc++;
    check_outputs();
    a[0] = ack0; a[1] = ack1;
    if (ack0 || ack1) begin
      last_ack_cyc = cyc; last_rd = rdata; last_err = err;
      acks.push_back(ack1 ? 1 : 0); ack_cycs.push_back(cyc);
    end
    for (int k = 0; k < 2; k++) begin
      if (a[k]) begin
        rq[k] = (mode == 1) || (mode == 2 && $urandom_range(1) == 1);
        if (mode == 2) begin opv[k] = 2'($urandom); ixv[k] = 2'($urandom); end
      end else if (mode == 2 && !rq[k] && $urandom_range(2) == 0) begin
        rq[k] = 1'b1; opv[k] = 2'($urandom); ixv[k] = 2'($urandom);
      end else if (mode == 2 && rq[k] && $urandom_range(3) == 0) begin
        opv[k] = 2'($urandom); ixv[k] = 2'($urandom);
      end
    end
  endtask

  task automatic load(input logic [3:0] v);
    load_val = v; load_en = 1'b1;
    tick();
    load_en = 1'b0; mb = v;
  endtask

  task automatic issue(input int k, input logic [1:0] o, input logic [1:0] ix);
    rq[k] = 1'b1; opv[k] = o; ixv[k] = ix; c = cyc;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin rq[k] = 1'b0; opv[k] = '0; ixv[k] = '0; end
    #1;
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_sr", 8'({s, r}), 8'd0);
    load(4'b0000);
    tick();
    rst_n = 1'b1;
    // set idx2 from q=0000
    issue(0, 2'b01, 2'd2);
    repeat (6) tick();
    chk("set_lat", 8'(last_ack_cyc - c), 8'd3);
    chk("set_rdata", 8'(last_rd), 8'd1);
    chk("set_err", 8'(last_err), 8'd0);
    chk("set_bank", 8'(tb_bank), 8'b0100);
    // toggle idx2 from q=0100
    issue(1, 2'b11, 2'd2);
    repeat (6) tick();
    chk("tgl_lat", 8'(last_ack_cyc - c), 8'd3);
    chk("tgl_rdata", 8'(last_rd), 8'd0);
    chk("tgl_err", 8'(last_err), 8'd0);
    // read idx3 from q=1010
    load(4'b1010);
    issue(0, 2'b00, 2'd3);
    repeat (6) tick();
    chk("rd_rdata", 8'(last_rd), 8'd1);
    chk("rd_err", 8'(last_err), 8'd0);
    chk("rd_bank", 8'(tb_bank), 8'b1010);
    // flag 1 stuck at 0
    load(4'b0000);
    stuck = 4'b0010;
    issue(0, 2'b01, 2'd1);
    repeat (6) tick();
    chk("flt_rdata", 8'(last_rd), 8'd0);
    chk("flt_err", 8'(last_err), 8'd1);
    stuck = 4'b0000;
    // contention held from reset
    rst_n = 1'b0;
    mode = 1;
    issue(0, 2'b11, 2'd0);
    issue(1, 2'b11, 2'd0);
    tick();
    rst_n = 1'b1;
    acks.delete(); ack_cycs.delete();
    c = cyc;
    repeat (16) tick();
    chk("cont_n", 8'(acks.size()), 8'd4);
    for (int i = 0; i < acks.size(); i++) begin
      chk("cont_id", 8'(acks[i]), 8'(i % 2));
      chk("cont_cyc", 8'(ack_cycs[i] - c), 8'(3 + 4 * i));
    end
    // reset in DRIVE after a req0 grant
    mode = 0;
    rq[0] = 1'b0; rq[1] = 1'b0;
    repeat (4) tick();
    issue(0, 2'b01, 2'd0);
    tick();
    chk("drv_s", 8'(s), 8'b0001);
    rst_n = 1'b0;
    #1;
    chk("abort_s", 8'(s), 8'd0);
    chk("abort_r", 8'(r), 8'd0);
    chk("abort_busy", 8'(busy), 8'd0);
    g_cyc = -100;
    issue(1, 2'b01, 2'd1);
    load(4'b0000);
    tick();
    rst_n = 1'b1;
    acks.delete(); ack_cycs.delete();
    repeat (8) tick();
    chk("post_rst_n", 8'(acks.size()), 8'd2);
    chk("post_rst_first", 8'(acks.size() > 0 ? acks[0] : 2), 8'd0);
    // random traffic with held and re-issued requests
    mode = 2;
    repeat (600) tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
